// File: rtl/pipe_pkg.sv
// Purpose: shared access-size codes, control bundle type and byte-enable helper for the memory pipeline.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: SZ_* size codes (code k = 2^k bytes), ctrl_t packed control bundle,
//           byte_en_mask(size, offset, nb) returning a lane mask up to MAX_NB lanes.
package pipe_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    // Widest lane count the helper can describe (1024-bit datapath).
    localparam int unsigned MAX_NB = 128;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } ctrl_t;

    // Lanes [off, off+2^size) set, clipped to nb lanes. Built per-lane rather than
    // with a shift so an oversized code can never overflow the shift amount.
    function automatic logic [MAX_NB-1:0] byte_en_mask(input int unsigned size_code,
                                                        input int unsigned off,
                                                        input int unsigned nb);
        logic [MAX_NB-1:0] m;
        int unsigned       sz;
        sz = 32'd1 << size_code;
        m  = '0;
        for (int unsigned i = 0; i < MAX_NB; i++) begin
            m[i] = (i >= off) && (i < off + sz) && (i < nb);
        end
        return m;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// Purpose: EX->MEM pipeline register bundle (E-side inputs, stall/flush, M-side outputs).
// Latency: n/a (signal container).
// Backpressure: stall_i holds the M stage; flush_i inserts a bubble.
// Modports: master drives E-side/stall/flush and observes M-side; slave is the pipeline register.
interface ex_mem_pipe_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SIZE_W     = 2,
    parameter int CNT_W      = 8
);
    localparam int NB = DATA_W / 8;

    logic                  stall_i;
    logic                  flush_i;
    logic                  valid_E;
    logic                  mem_read_E;
    logic                  mem_write_E;
    logic                  mem_to_reg_E;
    logic                  reg_write_E;
    logic [DATA_W-1:0]     alu_result_E;
    logic [DATA_W-1:0]     write_data_E;
    logic [REG_ADDR_W-1:0] write_reg_E;
    logic [SIZE_W-1:0]     data_size_E;

    logic                  valid_M;
    logic                  mem_read_M;
    logic                  mem_write_M;
    logic                  mem_to_reg_M;
    logic                  reg_write_M;
    logic [DATA_W-1:0]     alu_result_M;
    logic [DATA_W-1:0]     write_data_M;
    logic [NB-1:0]         byte_en_M;
    logic [REG_ADDR_W-1:0] write_reg_M;
    logic [SIZE_W-1:0]     data_size_M;
    logic                  misalign_M;
    logic [CNT_W-1:0]      stall_cnt_M;

    modport master (
        output stall_i, flush_i, valid_E, mem_read_E, mem_write_E, mem_to_reg_E, reg_write_E,
               alu_result_E, write_data_E, write_reg_E, data_size_E,
        input  valid_M, mem_read_M, mem_write_M, mem_to_reg_M, reg_write_M, alu_result_M,
               write_data_M, byte_en_M, write_reg_M, data_size_M, misalign_M, stall_cnt_M
    );

    modport slave (
        input  stall_i, flush_i, valid_E, mem_read_E, mem_write_E, mem_to_reg_E, reg_write_E,
               alu_result_E, write_data_E, write_reg_E, data_size_E,
        output valid_M, mem_read_M, mem_write_M, mem_to_reg_M, reg_write_M, alu_result_M,
               write_data_M, byte_en_M, write_reg_M, data_size_M, misalign_M, stall_cnt_M
    );

endinterface

// File: rtl/mem_align_dec.sv
// Purpose: byte-lane decode for a memory access: lane enables, store-data lane shift, misalign flag.
// Latency: combinational.
// Backpressure: none.
// Ports: off_i (byte offset in the word), data_size_i (2^k bytes), mem_en_i (valid memory op),
//        mem_write_i (store), write_data_i (right-justified) -> byte_en_o, wdata_o, misal_o.
module mem_align_dec
    import pipe_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int SIZE_W = 2,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [OFF_W-1:0]  off_i,
    input  logic [SIZE_W-1:0] data_size_i,
    input  logic              mem_en_i,
    input  logic              mem_write_i,
    input  logic [DATA_W-1:0] write_data_i,
    output logic [NB-1:0]     byte_en_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              misal_o
);

    logic             illegal;
    logic [OFF_W-1:0] low_mask;
    logic             misal;

    always_comb begin
        // An access wider than the datapath can never be placed.
        illegal = 32'(data_size_i) > 32'(OFF_W);

        // Offset bits below the access size must be zero for natural alignment.
        low_mask = '0;
        for (int i = 0; i < OFF_W; i++) begin
            low_mask[i] = i < int'(data_size_i);
        end

        misal     = mem_en_i & (illegal | (|(off_i & low_mask)));
        byte_en_o = (mem_en_i && !misal)
                  ? NB'(byte_en_mask(32'(data_size_i), 32'(off_i), 32'(NB)))
                  : '0;
        // The shift keys on the raw store flag so a right-justified store is
        // already lane-aligned even if the write is later squashed downstream.
        wdata_o   = (mem_write_i && !misal) ? (write_data_i << {off_i, 3'b000}) : write_data_i;
        misal_o   = misal;
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// Purpose: EX->MEM pipeline register with valid bit, lane alignment, misalign squash and stall profiling.
// Latency: 1 cycle E->M on a normal load.
// Backpressure: stall_i holds every register (counter excepted); flush_i loads a bubble and wins over stall_i.
// Ports: clk, rst_n (async active-low), bus (ex_mem_pipe_reg_if.slave: E-side in, M-side out).
module ex_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SIZE_W     = 2,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_mem_pipe_reg_if.slave   bus
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    logic                  mem_e;
    logic [NB-1:0]         dec_byte_en;
    logic [DATA_W-1:0]     dec_wdata;
    logic                  dec_misal;

    logic                  valid_q,      valid_d;
    ctrl_t                 ctrl_q,       ctrl_d;
    logic [DATA_W-1:0]     alu_result_q, alu_result_d;
    logic [DATA_W-1:0]     write_data_q, write_data_d;
    logic [NB-1:0]         byte_en_q,    byte_en_d;
    logic [REG_ADDR_W-1:0] write_reg_q,  write_reg_d;
    logic [SIZE_W-1:0]     data_size_q,  data_size_d;
    logic                  misalign_q,   misalign_d;
    logic [CNT_W-1:0]      stall_cnt_q,  stall_cnt_d;

    assign mem_e = bus.valid_E & (bus.mem_read_E | bus.mem_write_E);

    mem_align_dec #(
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W)
    ) u_align (
        .off_i        (bus.alu_result_E[OFF_W-1:0]),
        .data_size_i  (bus.data_size_E),
        .mem_en_i     (mem_e),
        .mem_write_i  (bus.mem_write_E),
        .write_data_i (bus.write_data_E),
        .byte_en_o    (dec_byte_en),
        .wdata_o      (dec_wdata),
        .misal_o      (dec_misal)
    );

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        byte_en_d    = byte_en_q;
        write_reg_d  = write_reg_q;
        data_size_d  = data_size_q;
        misalign_d   = misalign_q;
        stall_cnt_d  = '0;

        if (bus.flush_i) begin
            valid_d      = 1'b0;
            ctrl_d       = '0;
            alu_result_d = '0;
            write_data_d = '0;
            byte_en_d    = '0;
            write_reg_d  = '0;
            data_size_d  = '0;
            misalign_d   = 1'b0;
        end else if (bus.stall_i) begin
            // Only stalls that hold a live instruction count as hazard cycles.
            if (valid_q) begin
                stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d           = bus.valid_E;
            ctrl_d.mem_read   = bus.valid_E & bus.mem_read_E   & ~dec_misal;
            ctrl_d.mem_write  = bus.valid_E & bus.mem_write_E  & ~dec_misal;
            ctrl_d.mem_to_reg = bus.valid_E & bus.mem_to_reg_E & ~dec_misal;
            ctrl_d.reg_write  = bus.valid_E & bus.reg_write_E  & ~dec_misal;
            alu_result_d      = bus.alu_result_E;
            write_data_d      = dec_wdata;
            byte_en_d         = dec_byte_en;
            write_reg_d       = bus.write_reg_E;
            data_size_d       = bus.data_size_E;
            misalign_d        = dec_misal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            byte_en_q    <= '0;
            write_reg_q  <= '0;
            data_size_q  <= '0;
            misalign_q   <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            byte_en_q    <= byte_en_d;
            write_reg_q  <= write_reg_d;
            data_size_q  <= data_size_d;
            misalign_q   <= misalign_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.valid_M      = valid_q;
    assign bus.mem_read_M   = ctrl_q.mem_read;
    assign bus.mem_write_M  = ctrl_q.mem_write;
    assign bus.mem_to_reg_M = ctrl_q.mem_to_reg;
    assign bus.reg_write_M  = ctrl_q.reg_write;
    assign bus.alu_result_M = alu_result_q;
    assign bus.write_data_M = write_data_q;
    assign bus.byte_en_M    = byte_en_q;
    assign bus.write_reg_M  = write_reg_q;
    assign bus.data_size_M  = data_size_q;
    assign bus.misalign_M   = misalign_q;
    assign bus.stall_cnt_M  = stall_cnt_q;

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised EX→MEM pipeline register for the MIPS pipeline; successor to the fixed 32-bit EX/MEM latch.
- Adds a valid bit, stall hold and flush/bubble insertion, a registered byte-enable lane, store-data lane alignment, misaligned/illegal-size detection with access suppression, and a saturating stall-cycle counter for hazard profiling.

Parameters:
- DATA_W, 32, data/address width in bits; power of two, ≥16.
- REG_ADDR_W, 5, register-file address width.
- SIZE_W, 2, width of access-size code. Code k means 2^k bytes.
- CNT_W, 8, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hold all M-stage state this cycle.
- flush_i  in  1  load a bubble this cycle.
- valid_E  in  1  EX-stage instruction is valid.
- mem_read_E, mem_write_E, mem_to_reg_E, reg_write_E  in  1 each  EX control bits.
- alu_result_E  in  DATA_W  effective address / ALU result.
- write_data_E  in  DATA_W  store data, right-justified.
- write_reg_E  in  REG_ADDR_W  destination register.
- data_size_E  in  SIZE_W  access size code.
- valid_M  out  1  M-stage instruction valid.
- mem_read_M, mem_write_M, mem_to_reg_M, reg_write_M  out  1 each  gated control bits.
- alu_result_M  out  DATA_W  registered ALU result.
- write_data_M  out  DATA_W  store data shifted to the addressed byte lanes.
- byte_en_M  out  DATA_W/8  byte-lane enables.
- write_reg_M  out  REG_ADDR_W  destination register.
- data_size_M  out  SIZE_W  registered size code.
- misalign_M  out  1  registered instruction was a misaligned or illegal-size memory access.
- stall_cnt_M  out  CNT_W  consecutive stall cycles with valid_M=1.

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0.
- Update priority each rising edge, highest first:
  1. flush_i=1: load a bubble. All outputs become 0 except stall_cnt_M, which also clears. flush_i overrides stall_i.
  2. stall_i=1: all registers hold, except stall_cnt_M.
  3. Otherwise: normal load, single-cycle latency.
- Normal load, decode stage (combinational on E inputs):
  - NB = DATA_W/8. OFF = alu_result_E[log2(NB)-1:0]. SZ = 2^data_size_E bytes.
  - mem_E = valid_E & (mem_read_E | mem_write_E).
  - illegal = SZ > NB.
  - misal = mem_E & (illegal | (OFF mod SZ ≠ 0)).
- Normal load, registered results:
  - valid_M = valid_E.
  - misalign_M = misal.
  - mem_read_M = valid_E & mem_read_E & ~misal.
  - mem_write_M = valid_E & mem_write_E & ~misal.
  - reg_write_M = valid_E & reg_write_E & ~misal.
  - mem_to_reg_M = valid_E & mem_to_reg_E & ~misal.
  - byte_en_M = ((1<<SZ)-1) << OFF when mem_E & ~misal; otherwise 0.
  - write_data_M = write_data_E << (8*OFF) when mem_write_E & ~misal; otherwise write_data_E. Width truncated to DATA_W.
  - alu_result_M, write_reg_M and data_size_M load unconditionally.
- Invalid input: valid_E=0 forces every control output, byte_en_M and misalign_M to 0.
- Stall counter:
  - If stall_i=1 and valid_M=1 and flush_i=0: increment, saturating at 2^CNT_W−1.
  - Any cycle with stall_i=0 or valid_M=0: clear to 0.
- Reset mid-stall: registers clear immediately; no state survives.

Decomposition:
- Shared package (pipe_pkg):
  - Size-code constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3.
  - A function returning the byte-enable mask from (size, offset, NB).
- One sub-module, mem_align_dec: purely combinational. Inputs OFF, data_size, the mem flags and write_data. Outputs byte_en, shifted data and misal. It is reused by the MEM/WB load-extraction path.

Test Plan:
- Reset mid-stream: assert rst_n=0 asynchronously between clock edges → all outputs 0 before the next edge. Release, then valid word store to addr 0x100 with data 0x11223344 → next cycle byte_en_M=4'b1111, write_data_M=0x11223344, mem_write_M=1.
- Byte store, addr 0x103, data 0x000000AB, size 0 → byte_en_M=4'b1000, write_data_M=0xAB000000, misalign_M=0.
- Misaligned accesses:
  - Half load at 0x101 → misalign_M=1, mem_read_M=0, reg_write_M=0, byte_en_M=0.
  - Word at 0x102 → same result.
  - Size 3 when DATA_W=32 → misalign_M=1.
- Stall and counter: load valid instruction X, then stall_i=1 for 5 cycles while E inputs change → outputs hold X; stall_cnt_M reads 1,2,3,4,5, then returns to 0 after the stall drops and the new E instruction appears.
- Flush/stall priority: flush_i=1 and stall_i=1 together → valid_M=0, all controls 0, stall_cnt_M=0. Then valid_E=0 with reg_write_E=1 → reg_write_M=0.
- Saturation and width variants:
  - CNT_W=3, 12-cycle stall → stall_cnt_M saturates at 7.
  - DATA_W=64: size 3 at 0x108 → byte_en_M=8'hFF, misalign_M=0.
